// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } arb_state_e;

  localparam logic       PORT_CPU = 1'b0;
  localparam logic       PORT_LDR = 1'b1;
  localparam logic [3:0] BE_READ  = 4'b0000;

  // Wide enough for TIMEOUT up to 255 and any sensible STARVE_MAX.
  localparam int CNT_W = 8;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection: loader first, CPU forced once the loader has won STARVE_MAX times in a row.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic             i_cpu_req,
  input  logic             i_ldr_req,
  input  logic [CNT_W-1:0] i_starve_cnt,
  output logic             o_grant_valid,
  output logic             o_grant_port
);

  logic w_force_cpu;

  always_comb begin
    w_force_cpu   = i_cpu_req && (i_starve_cnt == CNT_W'(STARVE_MAX));
    o_grant_valid = i_cpu_req || i_ldr_req;
    o_grant_port  = (i_ldr_req && !w_force_cpu) ? PORT_LDR : PORT_CPU;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the CPU and the loader, one transaction at a time
// (IDLE -> ACCESS -> RESP), with wait states and a timeout that returns an error instead of hanging.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT    = 15,
  parameter int STARVE_MAX = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Cpu_req,
  input  logic [31:0] Cpu_addr,
  input  logic [31:0] Cpu_wdata,
  input  logic [3:0]  Cpu_byte_we,
  output logic        Cpu_ack,
  output logic [31:0] Cpu_rdata,
  output logic        Cpu_err,
  input  logic        Ldr_req,
  input  logic [31:0] Ldr_addr,
  input  logic [31:0] Ldr_wdata,
  input  logic [3:0]  Ldr_byte_we,
  output logic        Ldr_ack,
  output logic [31:0] Ldr_rdata,
  output logic        Ldr_err,
  output logic        Mem_en,
  output logic [29:0] Mem_addr,
  output logic [31:0] Mem_wdata,
  output logic [3:0]  Mem_byte_write,
  input  logic [31:0] Mem_rdata,
  input  logic        Mem_ready,
  output logic        Busy,
  output logic        Owner,
  output logic [1:0]  Dbg_state
);

  arb_state_e       r_state, w_next_state;
  logic [CNT_W-1:0] r_starve_cnt, r_wait_cnt;
  logic             r_owner;
  logic             r_mem_en;
  logic [29:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [3:0]       r_mem_be;
  logic             r_cpu_ack, r_cpu_err, r_ldr_ack, r_ldr_err;
  logic [31:0]      r_cpu_rdata, r_ldr_rdata;
  logic             w_grant_valid, w_grant_port;
  logic             w_timeout, w_access_done, w_busy;
  logic             w_unused_addr_lsbs;

  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .i_cpu_req     (Cpu_req),
    .i_ldr_req     (Ldr_req),
    .i_starve_cnt  (r_starve_cnt),
    .o_grant_valid (w_grant_valid),
    .o_grant_port  (w_grant_port)
  );

  // Ready on the timeout cycle still counts as success.
  assign w_timeout     = (r_wait_cnt == CNT_W'(TIMEOUT - 1));
  assign w_access_done = Mem_ready || w_timeout;

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_grant_valid) w_next_state = S_ACCESS;
      S_ACCESS: if (w_access_done) w_next_state = S_RESP;
      S_RESP:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  // Mem_* registers double as the captured request; they are zero whenever not in ACCESS.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_starve_cnt <= '0;
      r_wait_cnt   <= '0;
      r_owner      <= PORT_CPU;
      r_mem_en     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_be     <= '0;
      r_cpu_ack    <= 1'b0;
      r_cpu_err    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_ldr_ack    <= 1'b0;
      r_ldr_err    <= 1'b0;
      r_ldr_rdata  <= '0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_ldr_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wait_cnt <= '0;
          if (w_grant_valid) begin
            r_owner  <= w_grant_port;
            r_mem_en <= 1'b1;
            if (w_grant_port == PORT_LDR) begin
              r_mem_addr  <= Ldr_addr[31:2];
              r_mem_wdata <= Ldr_wdata;
              r_mem_be    <= Ldr_byte_we;
            end else begin
              r_mem_addr  <= Cpu_addr[31:2];
              r_mem_wdata <= Cpu_wdata;
              r_mem_be    <= Cpu_byte_we;
            end
            if (w_grant_port == PORT_LDR && Cpu_req) r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            else                                     r_starve_cnt <= '0;
          end
        end
        S_ACCESS: begin
          if (w_access_done) begin
            r_mem_en    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            if (r_owner == PORT_CPU) begin
              r_cpu_ack <= 1'b1;
              r_cpu_err <= !Mem_ready;
              if (r_mem_be == BE_READ) r_cpu_rdata <= Mem_ready ? Mem_rdata : 32'h0;
            end else begin
              r_ldr_ack <= 1'b1;
              r_ldr_err <= !Mem_ready;
              if (r_mem_be == BE_READ) r_ldr_rdata <= Mem_ready ? Mem_rdata : 32'h0;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_unused_addr_lsbs = ^{Cpu_addr[1:0], Ldr_addr[1:0]};

  assign Cpu_ack        = r_cpu_ack;
  assign Cpu_rdata      = r_cpu_rdata;
  assign Cpu_err        = r_cpu_err;
  assign Ldr_ack        = r_ldr_ack;
  assign Ldr_rdata      = r_ldr_rdata;
  assign Ldr_err        = r_ldr_err;
  assign Mem_en         = r_mem_en;
  assign Mem_addr       = r_mem_addr;
  assign Mem_wdata      = r_mem_wdata;
  assign Mem_byte_write = r_mem_be;
  assign Busy           = w_busy;
  assign Owner          = r_owner;
  assign Dbg_state      = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction table plus hand-written starvation, reset and corner sequences.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int TIMEOUT    = 15;
  localparam int STARVE_MAX = 4;
  localparam int NEVER      = -1;
  localparam int N_VEC      = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, ldr_req;
  logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
  logic [3:0]  cpu_be, ldr_be;
  logic        cpu_ack, cpu_err, ldr_ack, ldr_err;
  logic [31:0] cpu_rdata, ldr_rdata;
  logic        mem_en, mem_ready;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        busy, owner;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q[$];

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          wait_states;
    logic [31:0] mem_rdata;
    int          exp_ack_cycle;
    int          exp_en_cycles;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_other_rdata;
  } vec_t;

  vec_t vecs[N_VEC];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
    .Clk(clk), .Reset(rst),
    .Cpu_req(cpu_req), .Cpu_addr(cpu_addr), .Cpu_wdata(cpu_wdata), .Cpu_byte_we(cpu_be),
    .Cpu_ack(cpu_ack), .Cpu_rdata(cpu_rdata), .Cpu_err(cpu_err),
    .Ldr_req(ldr_req), .Ldr_addr(ldr_addr), .Ldr_wdata(ldr_wdata), .Ldr_byte_we(ldr_be),
    .Ldr_ack(ldr_ack), .Ldr_rdata(ldr_rdata), .Ldr_err(ldr_err),
    .Mem_en(mem_en), .Mem_addr(mem_addr), .Mem_wdata(mem_wdata), .Mem_byte_write(mem_be),
    .Mem_rdata(mem_rdata), .Mem_ready(mem_ready),
    .Busy(busy), .Owner(owner), .Dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_port(input logic port, input logic req, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
    if (port == PORT_LDR) begin
      ldr_req = req; ldr_addr = addr; ldr_wdata = wdata; ldr_be = be;
    end else begin
      cpu_req = req; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int          en_cycles, ack_cycle;
    logic        held_ok, other_ack;
    logic [29:0] exp_maddr;
    en_cycles = 0; ack_cycle = -1; held_ok = 1'b1; other_ack = 1'b0;
    exp_maddr = v.addr[31:2];
    drive_port(v.port, 1'b1, v.addr, v.wdata, v.be);
    mem_rdata = v.mem_rdata;
    mem_ready = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      mem_ready = mem_en && (v.wait_states >= 0) && (en_cycles == v.wait_states);
      @(negedge clk);
      if (mem_en) begin
        en_cycles++;
        if (mem_addr !== exp_maddr || mem_wdata !== v.wdata || mem_be !== v.be || owner !== v.port)
          held_ok = 1'b0;
      end
      if (v.port == PORT_LDR ? cpu_ack : ldr_ack) other_ack = 1'b1;
      if (v.port == PORT_LDR ? ldr_ack : cpu_ack) begin
        ack_cycle = c;
        break;
      end
    end
    check({tag, ".ack_cycle"}, ack_cycle, v.exp_ack_cycle);
    check({tag, ".en_cycles"}, en_cycles, v.exp_en_cycles);
    check({tag, ".mem_held"}, {31'h0, held_ok}, 32'h1);
    check({tag, ".other_ack"}, {31'h0, other_ack}, 32'h0);
    check({tag, ".rdata"}, v.port == PORT_LDR ? ldr_rdata : cpu_rdata, v.exp_rdata);
    check({tag, ".err"}, {31'h0, v.port == PORT_LDR ? ldr_err : cpu_err}, {31'h0, v.exp_err});
    check({tag, ".other_rdata"}, v.port == PORT_LDR ? cpu_rdata : ldr_rdata, v.exp_other_rdata);
    @(posedge clk); #1;
    drive_port(v.port, 1'b0, 32'h0, 32'h0, 4'h0);
    mem_ready = 1'b0;
    @(negedge clk);
    check({tag, ".ack_pulse"}, {31'h0, v.port == PORT_LDR ? ldr_ack : cpu_ack}, 32'h0);
    check({tag, ".idle_after"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    logic        prev_ack, dbl_pulse, bad_idle, seen_ack;
    int          acks, ack_cycle, en_cycles;

    vecs[0] = '{PORT_CPU, 32'h0000_1007, 32'h0000_0000, 4'b0000, 0,     32'hDEAD_BEEF, 2,  1,  32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vecs[1] = '{PORT_LDR, 32'h0000_2000, 32'h1234_5678, 4'b0011, 3,     32'hAAAA_5555, 5,  4,  32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{PORT_LDR, 32'h0000_300B, 32'h0000_0000, 4'b0000, 1,     32'hCAFE_F00D, 3,  2,  32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF};
    vecs[3] = '{PORT_CPU, 32'h0000_0100, 32'h0000_0000, 4'b0000, NEVER, 32'h1357_9BDF, 16, 15, 32'h0000_0000, 1'b1, 32'hCAFE_F00D};
    vecs[4] = '{PORT_CPU, 32'h0000_0104, 32'h0000_0000, 4'b0000, 0,     32'h0BAD_C0DE, 2,  1,  32'h0BAD_C0DE, 1'b0, 32'hCAFE_F00D};
    vecs[5] = '{PORT_CPU, 32'hFFFF_FFFC, 32'h0000_0000, 4'b0000, 14,    32'h5A5A_A5A5, 16, 15, 32'h5A5A_A5A5, 1'b0, 32'hCAFE_F00D};
    vecs[6] = '{PORT_CPU, 32'h0000_0200, 32'hFEED_FACE, 4'b1111, 2,     32'h9999_9999, 4,  3,  32'h5A5A_A5A5, 1'b0, 32'hCAFE_F00D};

    cpu_req = 0; cpu_addr = 0; cpu_wdata = 0; cpu_be = 0;
    ldr_req = 0; ldr_addr = 0; ldr_wdata = 0; ldr_be = 0;
    mem_ready = 0; mem_rdata = 0;
    do_reset();

    @(negedge clk);
    check("reset.mem_en", {31'h0, mem_en}, 32'h0);
    check("reset.mem_addr", {2'b0, mem_addr}, 32'h0);
    check("reset.mem_be", {28'h0, mem_be}, 32'h0);
    check("reset.busy_owner", {30'h0, busy, owner}, 32'h0);
    check("reset.acks", {30'h0, cpu_ack, ldr_ack}, 32'h0);
    check("reset.rdata", cpu_rdata | ldr_rdata, 32'h0);
    check("reset.state", {30'h0, dbg_state}, {30'h0, S_IDLE});

    for (int i = 0; i < N_VEC; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Mem_ready while idle must be ignored
    bad_idle = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1 mem_ready = 1'b1;
      @(negedge clk);
      if (busy || mem_en || cpu_ack || ldr_ack) bad_idle = 1'b1;
    end
    mem_ready = 1'b0;
    check("idle_ready.ignored", {31'h0, bad_idle}, 32'h0);

    // CPU drops req mid-access; ack still arrives
    drive_port(PORT_CPU, 1'b1, 32'h0000_0010, 32'h0, BE_READ);
    mem_rdata = 32'h7777_8888;
    en_cycles = 0; ack_cycle = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 2) cpu_req = 1'b0;
      mem_ready = mem_en && (en_cycles == 2);
      @(negedge clk);
      if (mem_en) en_cycles++;
      if (cpu_ack) begin ack_cycle = c; break; end
    end
    check("drop_req.ack_cycle", ack_cycle, 4);
    check("drop_req.rdata", cpu_rdata, 32'h7777_8888);
    @(posedge clk); #1 mem_ready = 1'b0;

    // starvation guard
    do_reset();
    exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    drive_port(PORT_CPU, 1'b1, 32'h0000_0400, 32'h0, BE_READ);
    drive_port(PORT_LDR, 1'b1, 32'h0000_0800, 32'h0, BE_READ);
    acks = 0; prev_ack = 1'b0; dbl_pulse = 1'b0;
    for (int c = 0; c < 200 && acks < 10; c++) begin
      @(posedge clk); #1;
      mem_ready = mem_en;
      mem_rdata = c;
      @(negedge clk);
      if (cpu_ack || ldr_ack) begin
        if (prev_ack || (cpu_ack && ldr_ack)) dbl_pulse = 1'b1;
        check($sformatf("starve.grant%0d", acks), {31'h0, ldr_ack}, {31'h0, exp_q.pop_front()});
        acks++;
      end
      prev_ack = cpu_ack || ldr_ack;
    end
    check("starve.ack_count", acks, 10);
    check("starve.single_pulse", {31'h0, dbl_pulse}, 32'h0);
    @(posedge clk); #1;
    cpu_req = 1'b0; ldr_req = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset during ACCESS, then the pending loader request is granted afresh
    drive_port(PORT_LDR, 1'b1, 32'h0000_0040, 32'h0, BE_READ);
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mid.in_access", {31'h0, mem_en & owner}, 32'h1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid.mem_en", {31'h0, mem_en}, 32'h0);
    check("rst_mid.mem_addr", {2'b0, mem_addr}, 32'h0);
    check("rst_mid.state", {30'h0, dbg_state}, {30'h0, S_IDLE});
    check("rst_mid.busy_owner", {30'h0, busy, owner}, 32'h0);
    check("rst_mid.acks", {30'h0, cpu_ack, ldr_ack}, 32'h0);
    check("rst_mid.rdata", cpu_rdata | ldr_rdata, 32'h0);
    @(posedge clk); #1;
    mem_ready = mem_en;
    mem_rdata = 32'h1111_2222;
    @(negedge clk);
    check("rst_mid.regrant", {30'h0, mem_en, owner}, 32'h3);
    seen_ack = 1'b0;
    for (int c = 0; c < 5 && !seen_ack; c++) begin
      @(posedge clk); #1 mem_ready = mem_en;
      @(negedge clk);
      if (ldr_ack) seen_ack = 1'b1;
    end
    check("rst_mid.ack", {31'h0, seen_ack}, 32'h1);
    check("rst_mid.ldr_rdata", ldr_rdata, 32'h1111_2222);
    @(posedge clk); #1;
    ldr_req = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
